// File: rtl/stream_number_checker_pkg.sv
// Shared types and elaboration-time helpers for the number-stream checker.
package stream_number_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Widest keep mask the helpers can describe (TDATA up to 1024 bits).
   localparam int MAX_KEEP_W = 128;

   function automatic int lane_width(input int tdata_w, input int num_w);
      return (num_w < tdata_w) ? num_w : tdata_w;
   endfunction

   function automatic int lanes(input int tdata_w, input int num_w);
      return tdata_w / lane_width(tdata_w, num_w);
   endfunction

   function automatic int num_beats(input int bytes, input int tdata_w);
      int bpb;
      bpb = tdata_w / 8;
      return (bytes + bpb - 1) / bpb;
   endfunction

   function automatic logic [MAX_KEEP_W-1:0] final_tkeep(input int bytes, input int tdata_w);
      int bpb;
      int rem;
      logic [MAX_KEEP_W-1:0] one;
      bpb = tdata_w / 8;
      rem = bytes % bpb;
      one = '0;
      one[0] = 1'b1;
      if (rem == 0) return {MAX_KEEP_W{1'b1}} >> (MAX_KEEP_W - bpb);
      return (one << rem) - one;
   endfunction

   function automatic int static_bits(input int l);
      return $clog2(l);
   endfunction

endpackage

// File: rtl/stream_number_checker_if.sv
// AXI4-Stream bundle between the number generator side and the checker.
interface stream_number_checker_if #(
   parameter int DATA_W = 128
) ();
   logic                  tvalid;
   logic                  tready;
   logic [DATA_W-1:0]     tdata;
   logic [DATA_W/8-1:0]   tkeep;
   logic                  tlast;

   modport master (output tvalid, tdata, tkeep, tlast, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/stream_number_checker_expect.sv
// Expected tdata for the current beat: every lane shares one beat counter in
// its upper bits, while the low bits are the constant lane index.
module stream_number_checker_expect
   import stream_number_checker_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int LW     = 32,
   parameter int SB     = 2
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              advance,
   output logic [DATA_W-1:0] exp_tdata
);
   localparam int L  = DATA_W / LW;
   localparam int CW = LW - SB;

   logic [CW-1:0] cnt_q, cnt_d;

   // Beat counter; wraps silently at 2^CW.
   always_comb begin
      cnt_d = cnt_q;
      if (clear)        cnt_d = '0;
      else if (advance) cnt_d = cnt_q + CW'(1);
   end

   // Register the beat counter.
   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   for (genvar n = 0; n < L; n++) begin : g_lane
      if (SB > 0) begin : g_idx
         localparam logic [SB-1:0] IDX = SB'(n);
         assign exp_tdata[n*LW +: LW] = {cnt_q, IDX};
      end else begin : g_noidx
         assign exp_tdata[n*LW +: LW] = cnt_q;
      end
   end

endmodule

// File: rtl/stream_number_checker.sv
// Sink that checks an incrementing-number AXI4-Stream beat by beat and
// reports sticky error flags, first failing beat and accepted beat count.
//
// state | meaning
// IDLE  | waiting for an ap_start rising edge, tready low
// RUN   | accepting and checking beats until beat NB-1 is taken
// DONE  | single cycle, ap_done high, then back to IDLE
module stream_number_checker
   import stream_number_checker_pkg::*;
#(
   parameter int C_S_AXIS_TDATA_WIDTH = 128,
   parameter int C_NUMBER_BIT_WIDTH   = 32,
   parameter int C_LENGTH_IN_BYTES    = 16384,
   parameter int C_THROTTLE           = 0
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   ap_start,
   output logic                   ap_done,
   stream_number_checker_if.slave s_axis,
   output logic                   err_data,
   output logic                   err_keep,
   output logic                   err_last,
   output logic [31:0]            first_err_beat,
   output logic [31:0]            beat_count
);
   localparam int TD  = C_S_AXIS_TDATA_WIDTH;
   localparam int LW  = lane_width(TD, C_NUMBER_BIT_WIDTH);
   localparam int L   = lanes(TD, C_NUMBER_BIT_WIDTH);
   localparam int SB  = static_bits(L);
   localparam int NB  = num_beats(C_LENGTH_IN_BYTES, TD);
   localparam int BPB = TD / 8;
   localparam logic [31:0]           LAST_BEAT    = 32'(NB - 1);
   localparam logic [31:0]           NO_ERR       = 32'hFFFF_FFFF;
   localparam logic [MAX_KEEP_W-1:0] KEEP_FINAL_W = final_tkeep(C_LENGTH_IN_BYTES, TD);
   localparam logic [BPB-1:0]        KEEP_FINAL   = KEEP_FINAL_W[BPB-1:0];
   localparam logic [BPB-1:0]        KEEP_ALL     = '1;
   localparam logic                  THROTTLE_ON  = (C_THROTTLE != 0);

   state_t      state_q, state_d;
   logic        ap_start_r_q, ap_start_r_d;
   logic        ap_done_q, ap_done_d;
   logic        tready_q, tready_d;
   logic        err_data_q, err_data_d;
   logic        err_keep_q, err_keep_d;
   logic        err_last_q, err_last_d;
   logic [31:0] first_err_beat_q, first_err_beat_d;
   logic [31:0] beat_count_q, beat_count_d;
   logic [1:0]  thr_cnt_q, thr_cnt_d;

   logic          go, accept, last_beat;
   logic          data_bad, keep_bad, last_bad;
   logic [TD-1:0] exp_tdata, keep_bits;
   logic [BPB-1:0] exp_keep;

   assign go        = (state_q == ST_IDLE) && ap_start && !ap_start_r_q;
   assign accept    = s_axis.tvalid && tready_q;
   assign last_beat = (beat_count_q == LAST_BEAT);

   stream_number_checker_expect #(
      .DATA_W (TD),
      .LW     (LW),
      .SB     (SB)
   ) u_expect (
      .clk       (aclk),
      .clear     (areset || go),
      .advance   (accept),
      .exp_tdata (exp_tdata)
   );

   // Compare the presented beat against the expected data, keep and last.
   always_comb begin
      keep_bits = '0;
      exp_keep  = last_beat ? KEEP_FINAL : KEEP_ALL;
      for (int i = 0; i < BPB; i++) keep_bits[i*8 +: 8] = {8{exp_keep[i]}};
      data_bad  = |((s_axis.tdata ^ exp_tdata) & keep_bits);
      keep_bad  = (s_axis.tkeep != exp_keep);
      last_bad  = (s_axis.tlast != last_beat);
   end

   // Next-state, error capture and throttle.
   always_comb begin
      state_d          = state_q;
      ap_start_r_d     = ap_start;
      err_data_d       = err_data_q;
      err_keep_d       = err_keep_q;
      err_last_d       = err_last_q;
      first_err_beat_d = first_err_beat_q;
      beat_count_d     = beat_count_q;
      thr_cnt_d        = thr_cnt_q + 2'd1;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               state_d          = ST_RUN;
               err_data_d       = 1'b0;
               err_keep_d       = 1'b0;
               err_last_d       = 1'b0;
               first_err_beat_d = NO_ERR;
               beat_count_d     = '0;
               thr_cnt_d        = '0;
            end
         end
         ST_RUN: begin
            if (accept) begin
               beat_count_d = beat_count_q + 32'd1;
               err_data_d   = err_data_q | data_bad;
               err_keep_d   = err_keep_q | keep_bad;
               err_last_d   = err_last_q | last_bad;
               if ((data_bad || keep_bad || last_bad) && (first_err_beat_q == NO_ERR))
                  first_err_beat_d = beat_count_q;
               if (last_beat) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      ap_done_d = (state_d == ST_DONE);
      tready_d  = (state_d == ST_RUN) && !(THROTTLE_ON && (thr_cnt_d == 2'd3));
   end

   // State and registered outputs; reset wins over a simultaneous start.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q          <= ST_IDLE;
         ap_start_r_q     <= 1'b0;
         ap_done_q        <= 1'b0;
         tready_q         <= 1'b0;
         err_data_q       <= 1'b0;
         err_keep_q       <= 1'b0;
         err_last_q       <= 1'b0;
         first_err_beat_q <= NO_ERR;
         beat_count_q     <= '0;
         thr_cnt_q        <= '0;
      end else begin
         state_q          <= state_d;
         ap_start_r_q     <= ap_start_r_d;
         ap_done_q        <= ap_done_d;
         tready_q         <= tready_d;
         err_data_q       <= err_data_d;
         err_keep_q       <= err_keep_d;
         err_last_q       <= err_last_d;
         first_err_beat_q <= first_err_beat_d;
         beat_count_q     <= beat_count_d;
         thr_cnt_q        <= thr_cnt_d;
      end
   end

   assign s_axis.tready  = tready_q;
   assign ap_done        = ap_done_q;
   assign err_data       = err_data_q;
   assign err_keep       = err_keep_q;
   assign err_last       = err_last_q;
   assign first_err_beat = first_err_beat_q;
   assign beat_count     = beat_count_q;

endmodule

// File: tb/tb_stream_number_checker.sv
// Bench for stream_number_checker: four configurations share one stimulus
// bus; per-check expectations are queued at start and popped on ap_done.
module tb_stream_number_checker;
   localparam int N_DUT = 4;
   localparam int C_NUM [N_DUT] = '{32, 32, 8, 32};
   localparam int C_LEN [N_DUT] = '{16384, 100, 512, 16384};
   localparam int C_THR [N_DUT] = '{0, 0, 0, 1};
   localparam logic [31:0] NO_ERR = 32'hFFFF_FFFF;

   typedef struct {
      int          sel;
      logic        ed;
      logic        ek;
      logic        el;
      logic [31:0] fe;
      logic [31:0] bc;
   } exp_t;

   logic         aclk = 1'b0;
   logic         areset = 1'b1;
   logic         start_v [N_DUT] = '{1'b0, 1'b0, 1'b0, 1'b0};
   logic         done_a [N_DUT];
   logic         ed_a [N_DUT];
   logic         ek_a [N_DUT];
   logic         el_a [N_DUT];
   logic         rdy_a [N_DUT];
   logic [31:0]  fe_a [N_DUT];
   logic [31:0]  bc_a [N_DUT];
   logic         vld = 1'b0;
   logic [127:0] tdata = '0;
   logic [15:0]  tkeep = '0;
   logic         tlast = 1'b0;
   int           sel = 0;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc_n = 0;
   int   done_cnt = 0;
   int   last_hs = 0;

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc_n <= cyc_n + 1;

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      stream_number_checker_if #(.DATA_W(128)) s_if ();
      assign s_if.tvalid = vld && (sel == g);
      assign s_if.tdata  = tdata;
      assign s_if.tkeep  = tkeep;
      assign s_if.tlast  = tlast;
      assign rdy_a[g]    = s_if.tready;

      stream_number_checker #(
         .C_S_AXIS_TDATA_WIDTH (128),
         .C_NUMBER_BIT_WIDTH   (C_NUM[g]),
         .C_LENGTH_IN_BYTES    (C_LEN[g]),
         .C_THROTTLE           (C_THR[g])
      ) u_dut (
         .aclk           (aclk),
         .areset         (areset),
         .ap_start       (start_v[g]),
         .ap_done        (done_a[g]),
         .s_axis         (s_if),
         .err_data       (ed_a[g]),
         .err_keep       (ek_a[g]),
         .err_last       (el_a[g]),
         .first_err_beat (fe_a[g]),
         .beat_count     (bc_a[g])
      );
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference beat: lane n of beat k holds (k*L + n) mod 2^lw.
   function automatic logic [127:0] model_beat(input int k, input int lw);
      logic [127:0]    b;
      longint unsigned v;
      int              l;
      b = '0;
      l = 128 / lw;
      for (int n = 0; n < l; n++) begin
         v = longint'(k) * longint'(l) + longint'(n);
         for (int j = 0; j < lw; j++) b[n*lw + j] = v[j];
      end
      return b;
   endfunction

   task automatic check_reset(input int s);
      check_eq("rst_tready", 32'(rdy_a[s]), 32'd0);
      check_eq("rst_done", 32'(done_a[s]), 32'd0);
      check_eq("rst_err_data", 32'(ed_a[s]), 32'd0);
      check_eq("rst_err_keep", 32'(ek_a[s]), 32'd0);
      check_eq("rst_err_last", 32'(el_a[s]), 32'd0);
      check_eq("rst_first_err", fe_a[s], NO_ERR);
      check_eq("rst_beat_count", bc_a[s], 32'd0);
   endtask

   // Scoreboard: each ap_done pulse retires the oldest queued expectation.
   always @(negedge aclk) begin
      exp_t e;
      for (int i = 0; i < N_DUT; i++) begin
         if (done_a[i] === 1'b1 && areset === 1'b0) begin
            if (exp_q.size() == 0) begin
               check_eq("done_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check_eq("done_dut", 32'(i), 32'(e.sel));
               check_eq("err_data", 32'(ed_a[i]), 32'(e.ed));
               check_eq("err_keep", 32'(ek_a[i]), 32'(e.ek));
               check_eq("err_last", 32'(el_a[i]), 32'(e.el));
               check_eq("first_err_beat", fe_a[i], e.fe);
               check_eq("beat_count", bc_a[i], e.bc);
               check_eq("done_latency", 32'(cyc_n), 32'(last_hs + 1));
               done_cnt++;
            end
         end
      end
   end

   task automatic run_check(input int s, input int flip_beat, input int keep_bad,
                            input int early_last, input int rnd_vld, input int start_glitch,
                            input int abort_at, input logic ed, input logic ek, input logic el,
                            input logic [31:0] efe);
      int           nb, lw, rem, k, cyc, stalls, done0;
      logic [127:0] d;
      logic [15:0]  kp;
      exp_t         e;
      lw  = (C_NUM[s] < 128) ? C_NUM[s] : 128;
      nb  = (C_LEN[s] + 15) / 16;
      rem = C_LEN[s] % 16;
      sel = s;
      if (abort_at < 0) begin
         e.sel = s; e.ed = ed; e.ek = ek; e.el = el; e.fe = efe; e.bc = 32'(nb);
         exp_q.push_back(e);
      end
      @(posedge aclk); #1 start_v[s] = 1'b1;
      @(posedge aclk); #1 start_v[s] = 1'b0;
      k = 0; cyc = 0; stalls = 0; done0 = done_cnt;
      while (k < nb && cyc < nb * 8 + 100) begin
         if (k == abort_at) break;
         d  = model_beat(k, lw);
         kp = 16'hFFFF;
         if (k == nb - 1 && rem != 0) begin
            for (int j = rem; j < 16; j++) d[j*8 +: 8] = 8'($urandom);
            if (keep_bad == 0) kp = (16'd1 << rem) - 16'd1;
         end
         if (k == flip_beat) d[40] = ~d[40];
         tdata = d;
         tkeep = kp;
         tlast = (early_last >= 0) ? (k == early_last) : (k == nb - 1);
         vld   = (rnd_vld != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         start_v[s] = (start_glitch >= 0) && (k >= start_glitch) && (k < start_glitch + 2);
         @(negedge aclk);
         if (vld && !rdy_a[s]) stalls++;
         if (vld && rdy_a[s]) begin
            if (k == nb - 1) last_hs = cyc_n;
            k++;
         end
         cyc++;
         @(posedge aclk); #1;
      end
      start_v[s] = 1'b0;
      if (abort_at >= 0) begin
         check_eq("abort_reached", 32'(k), 32'(abort_at));
         areset = 1'b1;
         vld    = 1'b0;
         @(posedge aclk); @(negedge aclk);
         check_reset(s);
         @(posedge aclk); #1 areset = 1'b0;
      end else begin
         check_eq("beats_accepted", 32'(k), 32'(nb));
         vld = 1'b1;
         cyc = 0;
         while (done_cnt == done0 && cyc < 50) begin
            @(negedge aclk);
            cyc++;
         end
         check_eq("done_seen", 32'(done_cnt - done0), 32'd1);
         if (done_cnt == done0) exp_q.delete();
         repeat (4) @(negedge aclk);
         check_eq("tready_after_done", 32'(rdy_a[s]), 32'd0);
         check_eq("beat_count_hold", bc_a[s], 32'(nb));
         check_eq("throttle_stall", 32'(stalls > 0), 32'(C_THR[s] != 0));
         @(posedge aclk); #1 vld = 1'b0;
      end
   endtask

   initial begin
      areset = 1'b1;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check_reset(0);
      check_reset(3);
      @(posedge aclk); #1 areset = 1'b0;
      // conformant full-length stream
      run_check(0, -1, 0, -1, 0, -1, -1, 1'b0, 1'b0, 1'b0, NO_ERR);
      // partial final beat, garbage in masked bytes
      run_check(1, -1, 0, -1, 0, -1, -1, 1'b0, 1'b0, 1'b0, NO_ERR);
      // partial final beat presented with full keep
      run_check(1, -1, 1, -1, 0, -1, -1, 1'b0, 1'b1, 1'b0, 32'd6);
      // single bit error in beat 5
      run_check(0, 5, 0, -1, 0, -1, -1, 1'b1, 1'b0, 1'b0, 32'd5);
      // tlast one beat early and missing on the final beat
      run_check(0, -1, 0, 1022, 0, -1, -1, 1'b0, 1'b0, 1'b1, 32'd1022);
      // 8-bit lanes wrap at beat 16
      run_check(2, -1, 0, -1, 0, -1, -1, 1'b0, 1'b0, 1'b0, NO_ERR);
      // throttled ready with random valid
      run_check(3, -1, 0, -1, 1, -1, -1, 1'b0, 1'b0, 1'b0, NO_ERR);
      // reset mid-run, then a clean full pass
      run_check(0, -1, 0, -1, 0, -1, 300, 1'b0, 1'b0, 1'b0, NO_ERR);
      run_check(0, -1, 0, -1, 0, -1, -1, 1'b0, 1'b0, 1'b0, NO_ERR);
      // start edge during RUN must be ignored
      run_check(0, -1, 0, -1, 0, 100, -1, 1'b0, 1'b0, 1'b0, NO_ERR);
      check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
